// File: rtl/alu_imm_pipeline_if.sv
// Bundles the ALU reg-imm issue port, the PRF read/forward operand buses and the
// writeback request. The slave modport is the pipeline; master is the surrounding core.
interface alu_imm_pipeline_if #(
  parameter int unsigned PRF_BANK_COUNT     = 4,
  parameter int unsigned LOG_PRF_BANK_COUNT = 2,
  parameter int unsigned LOG_PR_COUNT       = 7,
  parameter int unsigned LOG_ROB_ENTRIES    = 7
);
  logic                                 issue_valid;
  logic [3:0]                           issue_op;
  logic [11:0]                          issue_imm12;
  logic                                 issue_A_forward;
  logic                                 issue_A_is_zero;
  logic [LOG_PRF_BANK_COUNT-1:0]        issue_A_bank;
  logic [LOG_PR_COUNT-1:0]              issue_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]           issue_ROB_index;
  logic                                 issue_ready;

  logic                                 A_reg_read_ack;
  logic [PRF_BANK_COUNT-1:0][31:0]      reg_read_data_by_bank;
  logic [PRF_BANK_COUNT-1:0][31:0]      forward_data_by_bank;

  logic                                 WB_valid;
  logic [31:0]                          WB_data;
  logic [LOG_PR_COUNT-1:0]              WB_PR;
  logic [LOG_ROB_ENTRIES-1:0]           WB_ROB_index;
  logic                                 WB_ready;

  modport slave (
    input  issue_valid, issue_op, issue_imm12, issue_A_forward, issue_A_is_zero,
           issue_A_bank, issue_dest_PR, issue_ROB_index,
    output issue_ready,
    input  A_reg_read_ack, reg_read_data_by_bank, forward_data_by_bank,
    output WB_valid, WB_data, WB_PR, WB_ROB_index,
    input  WB_ready
  );

  modport master (
    output issue_valid, issue_op, issue_imm12, issue_A_forward, issue_A_is_zero,
           issue_A_bank, issue_dest_PR, issue_ROB_index,
    input  issue_ready,
    output A_reg_read_ack, reg_read_data_by_bank, forward_data_by_bank,
    input  WB_valid, WB_data, WB_PR, WB_ROB_index,
    output WB_ready
  );
endinterface

// File: rtl/alu_imm_pipeline.sv
// RV32I OP-IMM execution pipe: operand collect (OC) -> execute (EX) -> writeback request (WB).
// One op per stage, in order, with a valid/ready writeback that holds its payload until accepted.
module alu_imm_pipeline #(
  parameter int unsigned PRF_BANK_COUNT     = 4,
  parameter int unsigned LOG_PRF_BANK_COUNT = 2,
  parameter int unsigned LOG_PR_COUNT       = 7,
  parameter int unsigned LOG_ROB_ENTRIES    = 7
) (
  input logic               CLK,
  input logic               nRST,
  alu_imm_pipeline_if.slave bus
);

  localparam logic [1:0] ST_NEW  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HAVE = 2'd2;

  logic                          oc_valid_q, oc_valid_d;
  logic [1:0]                    oc_state_q, oc_state_d;
  logic [3:0]                    oc_op_q, oc_op_d;
  logic [11:0]                   oc_imm_q, oc_imm_d;
  logic                          oc_fwd_q, oc_fwd_d;
  logic                          oc_zero_q, oc_zero_d;
  logic [LOG_PRF_BANK_COUNT-1:0] oc_bank_q, oc_bank_d;
  logic [LOG_PR_COUNT-1:0]       oc_pr_q, oc_pr_d;
  logic [LOG_ROB_ENTRIES-1:0]    oc_rob_q, oc_rob_d;
  logic [31:0]                   saved_a_q, saved_a_d;

  logic                          ex_valid_q, ex_valid_d;
  logic [3:0]                    ex_op_q, ex_op_d;
  logic [11:0]                   ex_imm_q, ex_imm_d;
  logic [31:0]                   ex_a_q, ex_a_d;
  logic [LOG_PR_COUNT-1:0]       ex_pr_q, ex_pr_d;
  logic [LOG_ROB_ENTRIES-1:0]    ex_rob_q, ex_rob_d;

  logic                          wb_valid_q, wb_valid_d;
  logic [31:0]                   wb_data_q, wb_data_d;
  logic [LOG_PR_COUNT-1:0]       wb_pr_q, wb_pr_d;
  logic [LOG_ROB_ENTRIES-1:0]    wb_rob_q, wb_rob_d;

  logic        a_have_now;
  logic [31:0] a_now;
  logic        ex_advance, oc_advance, issue_ready, accept;
  logic [31:0] imm_sext, alu_result;
  logic [4:0]  shamt;

  always_comb begin
    // Operand A for the op in OC this cycle; zero beats forward beats PRF read.
    a_have_now = 1'b0;
    a_now      = '0;
    if (oc_valid_q) begin
      case (oc_state_q)
        ST_NEW: begin
          if (oc_zero_q) begin
            a_have_now = 1'b1;
          end else if (oc_fwd_q) begin
            a_have_now = 1'b1;
            a_now      = bus.forward_data_by_bank[oc_bank_q];
          end else if (bus.A_reg_read_ack) begin
            a_have_now = 1'b1;
            a_now      = bus.reg_read_data_by_bank[oc_bank_q];
          end
        end
        ST_WAIT: begin
          if (bus.A_reg_read_ack) begin
            a_have_now = 1'b1;
            a_now      = bus.reg_read_data_by_bank[oc_bank_q];
          end
        end
        ST_HAVE: begin
          a_have_now = 1'b1;
          a_now      = saved_a_q;
        end
        default: ;
      endcase
    end

    ex_advance  = ~wb_valid_q | bus.WB_ready;
    oc_advance  = oc_valid_q & a_have_now & (~ex_valid_q | ex_advance);
    issue_ready = ~oc_valid_q | oc_advance;
    accept      = bus.issue_valid & issue_ready;

    oc_valid_d = oc_valid_q;
    oc_state_d = oc_state_q;
    oc_op_d    = oc_op_q;
    oc_imm_d   = oc_imm_q;
    oc_fwd_d   = oc_fwd_q;
    oc_zero_d  = oc_zero_q;
    oc_bank_d  = oc_bank_q;
    oc_pr_d    = oc_pr_q;
    oc_rob_d   = oc_rob_q;
    saved_a_d  = saved_a_q;
    if (accept) begin
      oc_valid_d = 1'b1;
      oc_state_d = ST_NEW;
      oc_op_d    = bus.issue_op;
      oc_imm_d   = bus.issue_imm12;
      oc_fwd_d   = bus.issue_A_forward;
      oc_zero_d  = bus.issue_A_is_zero;
      oc_bank_d  = bus.issue_A_bank;
      oc_pr_d    = bus.issue_dest_PR;
      oc_rob_d   = bus.issue_ROB_index;
    end else if (oc_advance) begin
      oc_valid_d = 1'b0;
    end else if (oc_valid_q && a_have_now) begin
      // Blocked by EX: keep the forward/read value, those buses will not repeat it.
      oc_state_d = ST_HAVE;
      saved_a_d  = a_now;
    end else if (oc_valid_q && oc_state_q == ST_NEW) begin
      oc_state_d = ST_WAIT;
    end

    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_imm_d   = ex_imm_q;
    ex_a_d     = ex_a_q;
    ex_pr_d    = ex_pr_q;
    ex_rob_d   = ex_rob_q;
    if (oc_advance) begin
      ex_valid_d = 1'b1;
      ex_op_d    = oc_op_q;
      ex_imm_d   = oc_imm_q;
      ex_a_d     = a_now;
      ex_pr_d    = oc_pr_q;
      ex_rob_d   = oc_rob_q;
    end else if (ex_advance) begin
      ex_valid_d = 1'b0;
    end

    imm_sext = {{20{ex_imm_q[11]}}, ex_imm_q};
    shamt    = ex_imm_q[4:0];
    case (ex_op_q[2:0])
      3'b000:  alu_result = ex_a_q + imm_sext;
      3'b010:  alu_result = {31'b0, $signed(ex_a_q) < $signed(imm_sext)};
      3'b011:  alu_result = {31'b0, ex_a_q < imm_sext};
      3'b100:  alu_result = ex_a_q ^ imm_sext;
      3'b110:  alu_result = ex_a_q | imm_sext;
      3'b111:  alu_result = ex_a_q & imm_sext;
      3'b001:  alu_result = ex_a_q << shamt;
      3'b101:  alu_result = ex_op_q[3] ? 32'($signed(ex_a_q) >>> shamt) : (ex_a_q >> shamt);
      default: alu_result = '0;
    endcase

    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_pr_d    = wb_pr_q;
    wb_rob_d   = wb_rob_q;
    if (ex_valid_q && ex_advance) begin
      wb_valid_d = 1'b1;
      wb_data_d  = alu_result;
      wb_pr_d    = ex_pr_q;
      wb_rob_d   = ex_rob_q;
    end else if (bus.WB_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      oc_valid_q <= 1'b0;
      oc_state_q <= ST_NEW;
      oc_op_q    <= '0;
      oc_imm_q   <= '0;
      oc_fwd_q   <= 1'b0;
      oc_zero_q  <= 1'b0;
      oc_bank_q  <= '0;
      oc_pr_q    <= '0;
      oc_rob_q   <= '0;
      saved_a_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_imm_q   <= '0;
      ex_a_q     <= '0;
      ex_pr_q    <= '0;
      ex_rob_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_pr_q    <= '0;
      wb_rob_q   <= '0;
    end else begin
      oc_valid_q <= oc_valid_d;
      oc_state_q <= oc_state_d;
      oc_op_q    <= oc_op_d;
      oc_imm_q   <= oc_imm_d;
      oc_fwd_q   <= oc_fwd_d;
      oc_zero_q  <= oc_zero_d;
      oc_bank_q  <= oc_bank_d;
      oc_pr_q    <= oc_pr_d;
      oc_rob_q   <= oc_rob_d;
      saved_a_q  <= saved_a_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_imm_q   <= ex_imm_d;
      ex_a_q     <= ex_a_d;
      ex_pr_q    <= ex_pr_d;
      ex_rob_q   <= ex_rob_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_pr_q    <= wb_pr_d;
      wb_rob_q   <= wb_rob_d;
    end
  end

  assign bus.issue_ready  = issue_ready;
  assign bus.WB_valid     = wb_valid_q;
  assign bus.WB_data      = wb_data_q;
  assign bus.WB_PR        = wb_pr_q;
  assign bus.WB_ROB_index = wb_rob_q;

endmodule

// File: tb/tb_alu_imm_pipeline.sv
// Directed bench for alu_imm_pipeline: an in-order expected-result queue fed at issue time,
// checked against every writeback transfer, plus hand-computed literal expectations.
module tb_alu_imm_pipeline;
  localparam int unsigned NB = 4;
  localparam int unsigned LB = 2;
  localparam int unsigned LP = 7;
  localparam int unsigned LR = 7;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  alu_imm_pipeline_if #(
    .PRF_BANK_COUNT(NB), .LOG_PRF_BANK_COUNT(LB), .LOG_PR_COUNT(LP), .LOG_ROB_ENTRIES(LR)
  ) bus ();

  alu_imm_pipeline #(
    .PRF_BANK_COUNT(NB), .LOG_PRF_BANK_COUNT(LB), .LOG_PR_COUNT(LP), .LOG_ROB_ENTRIES(LR)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]   data;
    logic [LP-1:0] pr;
    logic [LR-1:0] rob;
  } wb_t;

  wb_t         exp_q[$];
  logic [31:0] wb_log[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural meaning of each OP-IMM encoding.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [11:0] imm12,
                                        input logic [31:0] a);
    logic signed [31:0] simm;
    int unsigned        sh;
    simm = {{20{imm12[11]}}, imm12};
    sh   = imm12[4:0];
    if (op[2:0] == 3'b000) return a + simm;
    if (op[2:0] == 3'b010) return ($signed(a) < simm) ? 32'd1 : 32'd0;
    if (op[2:0] == 3'b011) return (a < 32'(simm)) ? 32'd1 : 32'd0;
    if (op[2:0] == 3'b100) return a ^ simm;
    if (op[2:0] == 3'b110) return a | simm;
    if (op[2:0] == 3'b111) return a & simm;
    if (op[2:0] == 3'b001) return a << sh;
    if (op == 4'b1101)     return 32'($signed(a) >>> sh);
    return a >> sh;
  endfunction

  wb_t         e;
  logic        held = 1'b0;
  logic [31:0] held_data;
  logic [LP-1:0] held_pr;
  logic [LR-1:0] held_rob;

  always @(negedge CLK) begin
    if (!nRST) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("wb_hold_valid", {31'b0, bus.WB_valid}, 32'd1);
        chk("wb_hold_data", bus.WB_data, held_data);
        chk("wb_hold_pr", {25'b0, bus.WB_PR}, {25'b0, held_pr});
        chk("wb_hold_rob", {25'b0, bus.WB_ROB_index}, {25'b0, held_rob});
      end
      if (bus.WB_valid && bus.WB_ready) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", {31'b0, bus.WB_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_data", bus.WB_data, e.data);
          chk("wb_pr", {25'b0, bus.WB_PR}, {25'b0, e.pr});
          chk("wb_rob", {25'b0, bus.WB_ROB_index}, {25'b0, e.rob});
        end
        wb_log.push_back(bus.WB_data);
      end
      held      = bus.WB_valid && !bus.WB_ready;
      held_data = bus.WB_data;
      held_pr   = bus.WB_PR;
      held_rob  = bus.WB_ROB_index;
    end
  end

  // Presents one op, waits (bounded) for acceptance, records its expected result.
  // Returns 1 time unit after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [11:0] imm, input logic fwd,
                      input logic zero, input logic [1:0] bank, input logic [6:0] pr,
                      input logic [6:0] rob, input logic [31:0] a);
    int unsigned n;
    wb_t x;
    n = 0;
    bus.issue_valid     = 1'b1;
    bus.issue_op        = op;
    bus.issue_imm12     = imm;
    bus.issue_A_forward = fwd;
    bus.issue_A_is_zero = zero;
    bus.issue_A_bank    = bank;
    bus.issue_dest_PR   = pr;
    bus.issue_ROB_index = rob;
    @(negedge CLK);
    while (!bus.issue_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.issue_ready) begin
      chk("issue_timeout", {31'b0, bus.issue_ready}, 32'd1);
    end else begin
      x.data = model(op, imm, a);
      x.pr   = pr;
      x.rob  = rob;
      exp_q.push_back(x);
    end
    @(posedge CLK);
    #1;
    bus.issue_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.issue_valid           = 1'b0;
    bus.issue_op              = '0;
    bus.issue_imm12           = '0;
    bus.issue_A_forward       = 1'b0;
    bus.issue_A_is_zero       = 1'b0;
    bus.issue_A_bank          = '0;
    bus.issue_dest_PR         = '0;
    bus.issue_ROB_index       = '0;
    bus.A_reg_read_ack        = 1'b0;
    bus.reg_read_data_by_bank = '0;
    bus.forward_data_by_bank  = '0;
    bus.WB_ready              = 1'b1;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_wb_valid", {31'b0, bus.WB_valid}, 32'd0);
    chk("rst_wb_data", bus.WB_data, 32'd0);
    chk("rst_wb_pr", {25'b0, bus.WB_PR}, 32'd0);
    chk("rst_wb_rob", {25'b0, bus.WB_ROB_index}, 32'd0);
    chk("rst_issue_ready", {31'b0, bus.issue_ready}, 32'd1);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // ADDI of x0 with -1: lands at N+3, not earlier.
    send(4'b0000, 12'hFFF, 1'b0, 1'b1, 2'd0, 7'd5, 7'd3, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk("t1_not_early", {31'b0, bus.WB_valid}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk("t1_valid", {31'b0, bus.WB_valid}, 32'd1);
    chk("t1_data", bus.WB_data, 32'hFFFF_FFFF);
    chk("t1_pr", {25'b0, bus.WB_PR}, 32'd5);
    chk("t1_rob", {25'b0, bus.WB_ROB_index}, 32'd3);
    @(posedge CLK);
    #1;

    // SLLI by 4 on a forwarded operand.
    bus.forward_data_by_bank[2] = 32'h10;
    send(4'b0001, 12'h004, 1'b1, 1'b0, 2'd2, 7'd9, 7'd10, 32'h10);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("t2_valid", {31'b0, bus.WB_valid}, 32'd1);
    chk("t2_data", bus.WB_data, 32'h0000_0100);
    @(posedge CLK);
    #1;

    // SRAI 31 on a PRF read that is acked three cycles late; the next op waits behind it.
    bus.reg_read_data_by_bank[1] = 32'h8000_0000;
    send(4'b1101, 12'h41F, 1'b0, 1'b0, 2'd1, 7'd11, 7'd12, 32'h8000_0000);
    bus.issue_valid     = 1'b1;
    bus.issue_op        = 4'b0000;
    bus.issue_imm12     = 12'h007;
    bus.issue_A_forward = 1'b0;
    bus.issue_A_is_zero = 1'b1;
    bus.issue_dest_PR   = 7'd13;
    bus.issue_ROB_index = 7'd14;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("t3_ready_n2", {31'b0, bus.issue_ready}, 32'd0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("t3_ready_n3", {31'b0, bus.issue_ready}, 32'd0);
    @(posedge CLK);
    #1;
    bus.A_reg_read_ack = 1'b1;
    @(negedge CLK);
    chk("t3_ready_n4", {31'b0, bus.issue_ready}, 32'd1);
    e.data = model(4'b0000, 12'h007, 32'd0);
    e.pr   = 7'd13;
    e.rob  = 7'd14;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    bus.A_reg_read_ack = 1'b0;
    bus.issue_valid    = 1'b0;
    @(negedge CLK);
    chk("t3_not_early", {31'b0, bus.WB_valid}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk("t3_valid", {31'b0, bus.WB_valid}, 32'd1);
    chk("t3_data", bus.WB_data, 32'hFFFF_FFFF);
    repeat (3) @(posedge CLK);
    #1;

    // Compare/logic/shift mix over the read path with a permanent ack.
    wb_log.delete();
    bus.A_reg_read_ack           = 1'b1;
    bus.reg_read_data_by_bank[0] = 32'd5;
    bus.reg_read_data_by_bank[3] = 32'hFF;
    send(4'b0011, 12'hFFF, 1'b0, 1'b0, 2'd0, 7'd20, 7'd30, 32'd5);
    send(4'b0010, 12'hFFF, 1'b0, 1'b0, 2'd0, 7'd21, 7'd31, 32'd5);
    send(4'b0100, 12'h0F0, 1'b0, 1'b0, 2'd3, 7'd22, 7'd32, 32'hFF);
    send(4'b0111, 12'h0F0, 1'b0, 1'b0, 2'd3, 7'd23, 7'd33, 32'hFF);
    send(4'b0110, 12'h800, 1'b0, 1'b0, 2'd3, 7'd24, 7'd34, 32'hFF);
    send(4'b0101, 12'h404, 1'b0, 1'b0, 2'd1, 7'd25, 7'd35, 32'h8000_0000);
    send(4'b1000, 12'h001, 1'b0, 1'b0, 2'd0, 7'd26, 7'd36, 32'd5);
    send(4'b1001, 12'h01F, 1'b0, 1'b0, 2'd0, 7'd27, 7'd37, 32'd5);
    send(4'b0010, 12'h800, 1'b0, 1'b0, 2'd1, 7'd28, 7'd38, 32'h8000_0000);
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    bus.A_reg_read_ack = 1'b0;
    chk("t4_count", wb_log.size(), 32'd9);
    if (wb_log.size() == 9) begin
      chk("t4_sltiu", wb_log[0], 32'd1);
      chk("t4_slti", wb_log[1], 32'd0);
      chk("t4_xori", wb_log[2], 32'h0F);
      chk("t4_andi", wb_log[3], 32'hF0);
      chk("t4_ori", wb_log[4], 32'hFFFF_F8FF);
      chk("t4_srli", wb_log[5], 32'h0800_0000);
      chk("t4_addi_f7", wb_log[6], 32'd6);
      chk("t4_slli_f7", wb_log[7], 32'h8000_0000);
      chk("t4_slti_neg", wb_log[8], 32'd1);
    end
    @(posedge CLK);
    #1;

    // Writeback back-pressure: three ops fill WB/EX/OC, then drain one per cycle.
    wb_log.delete();
    bus.WB_ready = 1'b0;
    send(4'b0000, 12'h001, 1'b0, 1'b1, 2'd0, 7'd40, 7'd50, 32'd0);
    send(4'b0000, 12'h002, 1'b0, 1'b1, 2'd0, 7'd41, 7'd51, 32'd0);
    send(4'b0000, 12'h003, 1'b0, 1'b1, 2'd0, 7'd42, 7'd52, 32'd0);
    @(negedge CLK);
    chk("t5_ready_full", {31'b0, bus.issue_ready}, 32'd0);
    chk("t5_wb_held", {31'b0, bus.WB_valid}, 32'd1);
    chk("t5_wb_op0", bus.WB_data, 32'd1);
    repeat (2) @(posedge CLK);
    #1;
    bus.WB_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t5_drain_valid", {31'b0, bus.WB_valid}, 32'd1);
    end
    @(negedge CLK);
    chk("t5_drain_done", {31'b0, bus.WB_valid}, 32'd0);
    chk("t5_count", wb_log.size(), 32'd3);
    if (wb_log.size() == 3) begin
      chk("t5_order0", wb_log[0], 32'd1);
      chk("t5_order1", wb_log[1], 32'd2);
      chk("t5_order2", wb_log[2], 32'd3);
    end
    @(posedge CLK);
    #1;

    // Reset with all stages occupied: everything in flight is discarded.
    bus.WB_ready = 1'b0;
    send(4'b0000, 12'h011, 1'b0, 1'b1, 2'd0, 7'd60, 7'd70, 32'd0);
    send(4'b0000, 12'h022, 1'b0, 1'b1, 2'd0, 7'd61, 7'd71, 32'd0);
    send(4'b0000, 12'h033, 1'b0, 1'b1, 2'd0, 7'd62, 7'd72, 32'd0);
    @(negedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    chk("t6_wb_valid_async", {31'b0, bus.WB_valid}, 32'd0);
    chk("t6_wb_data_async", bus.WB_data, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    bus.WB_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("t6_no_stale", {31'b0, bus.WB_valid}, 32'd0);
    end
    chk("t6_ready", {31'b0, bus.issue_ready}, 32'd1);
    @(posedge CLK);
    #1;
    send(4'b0000, 12'h123, 1'b0, 1'b1, 2'd0, 7'd63, 7'd73, 32'd0);
    repeat (6) @(posedge CLK);
    @(negedge CLK);

    chk("model_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
